// File: rtl/test_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : test_vector_sequencer
// Purpose  : Plays back interleaved vectors (A0, B0, A1, B1, ...) from two
//            synchronous-read pattern memories, holding each for `hold` cycles.
//            Optional macro TEST_VECTOR_SEQ_LOOP_EN: sources wrap endlessly.
// Revision : 1.0 - initial release
// ============================================================================
module test_vector_sequencer #(
   parameter int VEC_W  = 8,
   parameter int ADDR_W = 6,
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] len_a,
   input  logic [ADDR_W-1:0] len_b,
   input  logic [HOLD_W-1:0] hold,
   output logic              rd_a_en,
   output logic [ADDR_W-1:0] rd_a_addr,
   input  logic [VEC_W-1:0]  rd_a_data,
   output logic              rd_b_en,
   output logic [ADDR_W-1:0] rd_b_addr,
   input  logic [VEC_W-1:0]  rd_b_data,
   output logic [VEC_W-1:0]  vector,
   output logic              vec_strobe,
   output logic              vec_src,
   output logic [ADDR_W:0]   vec_count,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] c_idx_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [HOLD_W-1:0] c_hold_one = {{(HOLD_W-1){1'b0}}, 1'b1};

   state_t              r_state;
   logic [ADDR_W-1:0]   r_len_a;
   logic [ADDR_W-1:0]   r_len_b;
   logic [ADDR_W-1:0]   r_idx_a;
   logic [ADDR_W-1:0]   r_idx_b;
   logic [HOLD_W-1:0]   r_hold_len;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic                r_turn_b;
   logic                r_sel_b;
   logic                r_rd_a_en;
   logic                r_rd_b_en;
   logic [ADDR_W-1:0]   r_rd_a_addr;
   logic [ADDR_W-1:0]   r_rd_b_addr;
   logic [VEC_W-1:0]    r_vector;
   logic                r_vec_strobe;
   logic                r_vec_src;
   logic [ADDR_W:0]     r_vec_count;
   logic                r_busy;
   logic                r_done;

   logic                w_a_avail;
   logic                w_b_avail;
   logic                w_pick_valid;
   logic                w_pick_b;
   logic [ADDR_W-1:0]   w_idx_a_inc;
   logic [ADDR_W-1:0]   w_idx_b_inc;
   logic [ADDR_W-1:0]   w_idx_a_next;
   logic [ADDR_W-1:0]   w_idx_b_next;

   assign w_a_avail    = (r_idx_a < r_len_a);
   assign w_b_avail    = (r_idx_b < r_len_b);
   assign w_pick_valid = w_a_avail | w_b_avail;
   // Honour the turn when that source still has vectors, otherwise fall back
   assign w_pick_b     = r_turn_b ? w_b_avail : ~w_a_avail;

   assign w_idx_a_inc  = r_idx_a + c_idx_one;
   assign w_idx_b_inc  = r_idx_b + c_idx_one;

`ifdef TEST_VECTOR_SEQ_LOOP_EN
   assign w_idx_a_next = (w_idx_a_inc == r_len_a) ? '0 : w_idx_a_inc;
   assign w_idx_b_next = (w_idx_b_inc == r_len_b) ? '0 : w_idx_b_inc;
`else
   assign w_idx_a_next = w_idx_a_inc;
   assign w_idx_b_next = w_idx_b_inc;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_len_a      <= '0;
         r_len_b      <= '0;
         r_idx_a      <= '0;
         r_idx_b      <= '0;
         r_hold_len   <= '0;
         r_hold_cnt   <= '0;
         r_turn_b     <= 1'b0;
         r_sel_b      <= 1'b0;
         r_rd_a_en    <= 1'b0;
         r_rd_b_en    <= 1'b0;
         r_rd_a_addr  <= '0;
         r_rd_b_addr  <= '0;
         r_vector     <= '0;
         r_vec_strobe <= 1'b0;
         r_vec_src    <= 1'b0;
         r_vec_count  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_rd_a_en    <= 1'b0;
         r_rd_b_en    <= 1'b0;
         r_vec_strobe <= 1'b0;
         r_done       <= 1'b0;

         if ((r_state != S_IDLE) && stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && !stop) begin
                     r_len_a     <= len_a;
                     r_len_b     <= len_b;
                     r_hold_len  <= (hold == '0) ? c_hold_one : hold;
                     r_idx_a     <= '0;
                     r_idx_b     <= '0;
                     r_vec_count <= '0;
                     r_turn_b    <= 1'b0;
                     r_busy      <= 1'b1;
                     if (len_a != '0) begin
                        r_state     <= S_FETCH;
                        r_sel_b     <= 1'b0;
                        r_rd_a_en   <= 1'b1;
                        r_rd_a_addr <= '0;
                     end else if (len_b != '0) begin
                        r_state     <= S_FETCH;
                        r_sel_b     <= 1'b1;
                        r_rd_b_en   <= 1'b1;
                        r_rd_b_addr <= '0;
                     end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end
                  end
               end

               S_FETCH: r_state <= S_LOAD;

               S_LOAD: begin
                  r_vector     <= r_sel_b ? rd_b_data : rd_a_data;
                  r_vec_src    <= r_sel_b;
                  r_turn_b     <= ~r_sel_b;
                  if (r_sel_b) begin
                     r_idx_b <= w_idx_b_next;
                  end else begin
                     r_idx_a <= w_idx_a_next;
                  end
                  r_vec_strobe <= 1'b1;
                  r_vec_count  <= r_vec_count + c_cnt_one;
                  r_hold_cnt   <= c_hold_one;
                  r_state      <= S_HOLD;
               end

               S_HOLD: begin
                  if (r_hold_cnt == r_hold_len) begin
                     if (w_pick_valid) begin
                        r_state <= S_FETCH;
                        r_sel_b <= w_pick_b;
                        if (w_pick_b) begin
                           r_rd_b_en   <= 1'b1;
                           r_rd_b_addr <= r_idx_b;
                        end else begin
                           r_rd_a_en   <= 1'b1;
                           r_rd_a_addr <= r_idx_a;
                        end
                     end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_hold_cnt <= r_hold_cnt + c_hold_one;
                  end
               end

               S_DONE: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end

               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rd_a_en    = r_rd_a_en;
   assign rd_a_addr  = r_rd_a_addr;
   assign rd_b_en    = r_rd_b_en;
   assign rd_b_addr  = r_rd_b_addr;
   assign vector     = r_vector;
   assign vec_strobe = r_vec_strobe;
   assign vec_src    = r_vec_src;
   assign vec_count  = r_vec_count;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_test_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_vector_sequencer
// Purpose  : Directed scoreboard bench for test_vector_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_vector_sequencer;

   localparam int VEC_W  = 8;
   localparam int ADDR_W = 6;
   localparam int HOLD_W = 8;

   logic              clk;
   logic              rst;
   logic              start;
   logic              stop;
   logic [ADDR_W-1:0] len_a;
   logic [ADDR_W-1:0] len_b;
   logic [HOLD_W-1:0] hold;
   logic              rd_a_en;
   logic [ADDR_W-1:0] rd_a_addr;
   logic [VEC_W-1:0]  rd_a_data;
   logic              rd_b_en;
   logic [ADDR_W-1:0] rd_b_addr;
   logic [VEC_W-1:0]  rd_b_data;
   logic [VEC_W-1:0]  vector;
   logic              vec_strobe;
   logic              vec_src;
   logic [ADDR_W:0]   vec_count;
   logic              busy;
   logic              done;

   test_vector_sequencer #(
      .VEC_W  (VEC_W),
      .ADDR_W (ADDR_W),
      .HOLD_W (HOLD_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .len_a      (len_a),
      .len_b      (len_b),
      .hold       (hold),
      .rd_a_en    (rd_a_en),
      .rd_a_addr  (rd_a_addr),
      .rd_a_data  (rd_a_data),
      .rd_b_en    (rd_b_en),
      .rd_b_addr  (rd_b_addr),
      .rd_b_data  (rd_b_data),
      .vector     (vector),
      .vec_strobe (vec_strobe),
      .vec_src    (vec_src),
      .vec_count  (vec_count),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [VEC_W-1:0] vec;
      logic             src;
      int               cyc;
      int               cnt;
   } exp_t;

   exp_t             q[$];
   logic [VEC_W-1:0] mem_a [64];
   logic [VEC_W-1:0] mem_b [64];
   int               n_checks  = 0;
   int               n_errors  = 0;
   int               cyc       = 0;
   int               t0        = 0;
   int               exp_done  = -1;
   int               done_seen = 0;
   int               rd_cnt    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Pattern memories: synchronous read, one-cycle latency
   always @(posedge clk) begin
      if (rd_a_en) rd_a_data <= mem_a[rd_a_addr];
      if (rd_b_en) rd_b_data <= mem_b[rd_b_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rd_a_en || rd_b_en) begin
         rd_cnt++;
         chk("rd_exclusive", {31'b0, rd_a_en & rd_b_en}, 32'd0);
      end
      if (vec_strobe) begin
         chk("strobe_expected", {31'b0, q.size() != 0}, 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("vector", {24'b0, vector}, {24'b0, e.vec});
            chk("vec_src", {31'b0, vec_src}, {31'b0, e.src});
            chk("strobe_cycle", cyc - t0, e.cyc);
            chk("vec_count", {25'b0, vec_count}, e.cnt);
         end
      end
      if (done) begin
         done_seen++;
         chk("done_cycle", cyc - t0, exp_done);
      end
   end

   task automatic push_exp(input logic [VEC_W-1:0] v, input logic s, input int c, input int n);
      exp_t e;
      e.vec = v; e.src = s; e.cyc = c; e.cnt = n;
      q.push_back(e);
   endtask

   task automatic start_seq(input int la, input int lb, input int h);
      @(negedge clk);
      len_a     = ADDR_W'(la);
      len_b     = ADDR_W'(lb);
      hold      = HOLD_W'(h);
      start     = 1'b1;
      t0        = cyc;
      done_seen = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_seq(input int cnt_exp);
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", {31'b0, busy}, 32'd0);
      chk("busy_drop_cycle", cyc - t0, exp_done + 1);
      chk("done_seen", done_seen, 1);
      chk("final_count", {25'b0, vec_count}, cnt_exp);
      chk("sb_leftover", q.size(), 0);
   endtask

   task automatic chk_all_zero();
      chk("z_vector", {24'b0, vector}, 0);
      chk("z_vec_src", {31'b0, vec_src}, 0);
      chk("z_vec_count", {25'b0, vec_count}, 0);
      chk("z_vec_strobe", {31'b0, vec_strobe}, 0);
      chk("z_busy", {31'b0, busy}, 0);
      chk("z_done", {31'b0, done}, 0);
      chk("z_rd_en", {30'b0, rd_a_en, rd_b_en}, 0);
      chk("z_rd_addr", {20'b0, rd_a_addr, rd_b_addr}, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int rd_before;
      int n;
      for (int i = 0; i < 64; i++) begin
         mem_a[i] = VEC_W'(8'hA0 + i);
         mem_b[i] = VEC_W'(8'hC0 + i);
      end
      mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h55;
      mem_b[0] = 8'h33; mem_b[1] = 8'h44;

      rst = 1'b1; start = 1'b0; stop = 1'b0; len_a = '0; len_b = '0; hold = '0;
      repeat (3) @(negedge clk);
      chk_all_zero();
      rst = 1'b0;

      // Basic interleave
      exp_done = 13;
      push_exp(8'h11, 1'b0, 3, 1);
      push_exp(8'h33, 1'b1, 6, 2);
      push_exp(8'h22, 1'b0, 9, 3);
      push_exp(8'h44, 1'b1, 12, 4);
      start_seq(2, 2, 1);
      chk("busy_after_start", {31'b0, busy}, 1);
      finish_seq(4);

      // Unequal lengths
      exp_done = 17;
      push_exp(8'h11, 1'b0, 3, 1);
      push_exp(8'h33, 1'b1, 7, 2);
      push_exp(8'h22, 1'b0, 11, 3);
      push_exp(8'h55, 1'b0, 15, 4);
      start_seq(3, 1, 2);
      finish_seq(4);

      // Empty sources
      exp_done  = 1;
      rd_before = rd_cnt;
      start_seq(0, 0, 5);
      finish_seq(0);
      chk("empty_no_reads", rd_cnt - rd_before, 0);

      // hold=0 behaves as hold=1
      exp_done = 4;
      push_exp(8'h11, 1'b0, 3, 1);
      start_seq(1, 0, 0);
      finish_seq(1);

      // Abort during LOAD of second vector (cycle 5)
      exp_done = -1;
      push_exp(8'h11, 1'b0, 3, 1);
      start_seq(2, 2, 1);
      repeat (4) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_vector", {24'b0, vector}, 32'h11);
      chk("abort_count", {25'b0, vec_count}, 1);
      repeat (10) @(negedge clk);
      chk("abort_done_seen", done_seen, 0);
      chk("abort_leftover", q.size(), 0);

      // start with stop in IDLE stays idle
      rd_before = rd_cnt;
      @(negedge clk);
      len_a = 6'd2; len_b = 6'd2; hold = 8'd1;
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", {31'b0, busy}, 0);
      repeat (5) @(negedge clk);
      chk("startstop_no_reads", rd_cnt - rd_before, 0);
      chk("startstop_count", {25'b0, vec_count}, 1);

      // Reset mid-HOLD
      exp_done = -1;
      push_exp(8'h11, 1'b0, 3, 1);
      start_seq(2, 2, 3);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero();
      rst = 1'b0;
      chk("rst_leftover", q.size(), 0);
      @(negedge clk);

      // start pulsed while busy is ignored
      exp_done = 13;
      push_exp(8'h11, 1'b0, 3, 1);
      push_exp(8'h33, 1'b1, 6, 2);
      push_exp(8'h22, 1'b0, 9, 3);
      push_exp(8'h44, 1'b1, 12, 4);
      start_seq(2, 2, 1);
      repeat (3) @(negedge clk);
      len_a = 6'd1; len_b = 6'd0; hold = 8'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_seq(4);

`ifdef TEST_VECTOR_SEQ_LOOP_EN
      // Loop build: endless A0/B0 alternation, count wraps past 127
      exp_done = -1;
      for (int k = 0; k < 130; k++) begin
         push_exp((k % 2 == 0) ? 8'h11 : 8'h33, 1'(k % 2), 3 + 3 * k, (k + 1) % 128);
      end
      start_seq(1, 1, 0);
      n = 0;
      while (q.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("loop_drained", q.size(), 0);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("loop_stop_busy", {31'b0, busy}, 0);
      chk("loop_wrap_count", {25'b0, vec_count}, 2);
      chk("loop_no_done", done_seen, 0);
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/test_vector_sequencer.md
# test_vector_sequencer

- Synthesizable controller that plays back stored test vectors from two pattern memories, A and B, onto one vector bus feeding the design under test.
- Sequences reads from both memories, interleaves the two streams (A0, B0, A1, B1, …), and holds each vector for a programmable number of clock cycles.
- Signals completion to the bench or on-chip self-test logic.
- Sits between the pattern memories (synchronous-read, one-cycle latency) and the DUT stimulus inputs.

## Interface
- VEC_W, 8, vector width
- ADDR_W, 6, pattern-memory address width; max vectors per source 2^ADDR_W − 1
- HOLD_W, 8, width of hold-cycle count

Ports: clock and reset are `clk` (one clock) and `rst`, which is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin playback (sampled in IDLE only)
- stop  in  1  abort playback
- len_a  in  ADDR_W  number of vectors in source A
- len_b  in  ADDR_W  number of vectors in source B
- hold  in  HOLD_W  cycles each vector is held (0 treated as 1)
- rd_a_en  out  1  read strobe to memory A
- rd_a_addr  out  ADDR_W  read address to memory A
- rd_a_data  in  VEC_W  memory A data, valid cycle after rd_a_en
- rd_b_en / rd_b_addr / rd_b_data: same as A, for memory B
- vector  out  VEC_W  current stimulus vector
- vec_strobe  out  1  one-cycle pulse: new vector on `vector`
- vec_src  out  1  source of current vector (0 = A, 1 = B)
- vec_count  out  ADDR_W+1  vectors issued since start
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at normal completion

## Operation
- **Reset values:** every output is 0; FSM in IDLE; both source indices 0.
- **FSM states:** IDLE, FETCH, LOAD, HOLD, DONE.
- **IDLE:**
  - `start`=1 and `stop`=0: latch len_a, len_b, hold (0 latched as 1); clear indices and vec_count.
  - If len_a=len_b=0, go to DONE; else go to FETCH.
- **Source selection:**
  - Sources alternate, A first.
  - If the selected source is exhausted (index == len), take the other.
  - When both are exhausted, go to DONE.
- **FETCH:** assert rd_x_en for exactly one cycle with rd_x_addr = index of the selected source; go to LOAD.
- **LOAD:** register rd_x_data into `vector` and set vec_src; increment that source's index; go to HOLD.
- **HOLD:**
  - First HOLD cycle: vec_strobe=1, and vec_count increments.
  - Remain in HOLD for `hold` cycles total, then go to FETCH (or DONE if both sources are exhausted).
- **DONE:** done=1 for one cycle, then IDLE.
- **Output retention:** `vector`, vec_src and vec_count keep their last values in IDLE and DONE.
- **stop:**
  - In any non-IDLE state, go to IDLE next cycle with no done pulse.
  - An outstanding read's data is discarded; `vector` is not updated.
  - stop has priority over start and over every transition.
- `start` while busy is ignored.
- `rst` mid-operation forces the reset values on the next edge.

## Timing
- Start accepted at cycle 0: FETCH is cycle 1, LOAD is cycle 2, first vec_strobe is cycle 3.
- Vector period is hold+2 cycles; successive strobes are exactly hold+2 cycles apart.
- done is asserted the cycle after the last HOLD cycle.
- busy deasserts the cycle after done.
- With len_a=len_b=0, done is asserted at cycle 1.
- At most one of rd_a_en and rd_b_en is high in any cycle.

## Configuration
- Macro: `TEST_VECTOR_SEQ_LOOP_EN`.
- **Defined:**
  - On exhaustion, a source's index wraps to 0 instead of finishing; playback runs until `stop`.
  - A source with len=0 is still skipped; len_a=len_b=0 still goes to DONE.
  - vec_count wraps modulo 2^(ADDR_W+1).
- **Undefined:** playback ends in DONE as described above; no wrap logic is synthesized.

## Test plan
- **Basic interleave:**
  - Setup: len_a=2, len_b=2, hold=1, A={0x11,0x22}, B={0x33,0x44}; start at cycle 0.
  - Expected: strobes at cycles 3, 6, 9, 12 with vectors 0x11, 0x33, 0x22, 0x44 and vec_src 0, 1, 0, 1.
  - Expected: done at cycle 13, vec_count=4.
- **Unequal lengths:**
  - Setup: len_a=3, len_b=1, hold=2.
  - Expected: order A0, B0, A1, A2 with strobes 4 cycles apart; done after the 4th vector.
- **Empty and hold=0:**
  - len_a=len_b=0 → done at cycle 1, no rd_*_en, vec_count=0.
  - len_a=1, len_b=0, hold=0 → behaves as hold=1.
- **Abort:**
  - Assert stop during the LOAD of the second vector.
  - Expected: IDLE next cycle, no done, `vector` still holds the first vector, busy=0.
  - Assert start and stop together in IDLE → remains IDLE.
- **Reset and busy start:**
  - rst mid-HOLD → all outputs 0 next cycle.
  - start pulsed while busy → no restart, sequence unchanged.
- **Loop build (`TEST_VECTOR_SEQ_LOOP_EN` defined):**
  - Setup: len_a=1, len_b=1.
  - Expected: vectors A0, B0, A0, B0… continue until stop, with no done; vec_count wraps past 127 to 0 (ADDR_W=6).
